seq_detect_scheduler: RTL and testbench

- Time-multiplexes one overlapping Mealy pattern-detection engine across NUM_CH independent serial bit streams.
- Each channel offers one bit per handshake. A round-robin arbiter grants at most one channel per cycle.
- The engine checks the granted bit against that channel's saved bit history and the programmed pattern, then writes the updated history back.
- Sits between serial front-ends and the event/interrupt logic. Replaces NUM_CH private detectors.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/seq_detect_scheduler.sv | 129 ++++++++++++
 tb/tb_seq_detect_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the time-multiplexed pattern detector.
// Counter support in the top level is enabled with the SEQ_CNT_EN macro.
package seq_detect_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W   = 8;

  // Contexts are sized for the largest pattern; the top masks unused history bits.
  localparam int MAX_PAT_LEN = 16;
  localparam int HIST_W      = MAX_PAT_LEN - 1;
  localparam int FILL_W      = 4;

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic [FILL_W-1:0] fill;
  } ctx_t;

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] fill,
                                                 input logic [FILL_W-1:0] lim);
    return (fill >= lim) ? fill : fill + FILL_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any_gnt
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One overlapping Mealy pattern detector shared round-robin across NUM_CH bit streams.
// Define SEQ_CNT_EN to add per-channel saturating match counters with a read/clear port.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [PAT_LEN-1:0]        cfg_pattern,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_bit,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic                      match_valid,
  output logic [$clog2(NUM_CH)-1:0] match_ch,
  input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_out
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [MAX_PAT_LEN-1:0] WIN_MASK  = MAX_PAT_LEN'((1 << PAT_LEN) - 1);
  localparam logic [HIST_W-1:0]      HIST_MASK = HIST_W'((1 << (PAT_LEN - 1)) - 1);
  localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]  req, gnt, hit;
  logic [CH_W-1:0]    gnt_idx;
  logic               any_gnt;

  // Grants are suppressed during configuration and while reset is held.
  assign req = ch_valid & {NUM_CH{rst_n & ~cfg_we}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign ch_ready    = gnt;
  assign match_valid = |(gnt & hit);
  assign match_ch    = match_valid ? gnt_idx : '0;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ctx_t                   ctx_q, ctx_d;
    logic [MAX_PAT_LEN-1:0] win;

    assign win     = {ctx_q.hist, ch_bit[gi]};
    assign hit[gi] = (ctx_q.fill == FILL_FULL) &&
                     ((win & WIN_MASK) == MAX_PAT_LEN'(pat_q));

    always_comb begin
      ctx_d = ctx_q;
      if (cfg_we) begin
        ctx_d = '0;
      end else if (gnt[gi]) begin
        ctx_d.hist = win[HIST_W-1:0] & HIST_MASK;
        ctx_d.fill = fill_inc(ctx_q.fill, FILL_FULL);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctx_q <= '0;
      else        ctx_q <= ctx_d;
    end
  end

  always_comb begin
    pat_d    = cfg_we ? cfg_pattern : pat_q;
    rr_ptr_d = rr_ptr_q;
    if (cfg_we) begin
      rr_ptr_d = '0;
    end else if (any_gnt) begin
      rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      pat_q    <= pat_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef SEQ_CNT_EN
  // Padded to a power of two so any cnt_sel value reads a defined entry.
  logic [CNT_W-1:0] cnt_val [2**CH_W];

  for (genvar gi = 0; gi < 2**CH_W; gi++) begin : g_cnt
    if (gi < NUM_CH) begin : g_real
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cfg_we || (cnt_clr && (cnt_sel == CH_W'(gi)))) begin
          cnt_d = '0;
        end else if (gnt[gi] && hit[gi] && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign cnt_val[gi] = cnt_q;
    end else begin : g_pad
      assign cnt_val[gi] = '0;
    end
  end

  assign cnt_out = cnt_val[cnt_sel];
`else
  logic unused_cnt_ok;
  assign unused_cnt_ok = ^{cnt_sel, cnt_clr};
  assign cnt_out       = '0;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler against a bit-stream reference model.
// Counter checks follow the SEQ_CNT_EN macro used for the DUT build.
module tb_seq_detect_scheduler;

  localparam int NUM_CH  = 4;
  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 8;
  localparam int CH_W    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PMASK   = (1 << PAT_LEN) - 1;
`ifdef SEQ_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [PAT_LEN-1:0] cfg_pattern = '0;
  logic [NUM_CH-1:0]  ch_valid = '0;
  logic [NUM_CH-1:0]  ch_bit = '0;
  logic [NUM_CH-1:0]  ch_ready;
  logic               match_valid;
  logic [CH_W-1:0]    match_ch;
  logic [CH_W-1:0]    cnt_sel = '0;
  logic               cnt_clr = 1'b0;
  logic [CNT_W-1:0]   cnt_out;

  seq_detect_scheduler #(.NUM_CH(NUM_CH), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .cnt_sel     (cnt_sel),
    .cnt_clr     (cnt_clr),
    .cnt_out     (cnt_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: last PAT_LEN bits as an integer plus total bits seen per channel.
  int ptr_m, pat_m;
  int hist_m [NUM_CH];
  int nbits_m [NUM_CH];
  int cnt_m [NUM_CH];

  logic [NUM_CH-1:0] exp_ready;
  logic              exp_mv;
  logic [CH_W-1:0]   exp_mch;
  logic [CNT_W-1:0]  exp_cnt;
  int                exp_g, exp_nv;

  task automatic clear_model();
    pat_m = 0;
    ptr_m = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      hist_m[c] = 0; nbits_m[c] = 0; cnt_m[c] = 0;
    end
  endtask

  task automatic model_eval();
    exp_ready = '0; exp_mv = 1'b0; exp_mch = '0; exp_g = -1; exp_nv = 0;
    if (rst_n && !cfg_we) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (ptr_m + k) % NUM_CH;
        if (exp_g < 0 && ch_valid[c]) exp_g = c;
      end
    end
    if (exp_g >= 0) begin
      exp_ready[exp_g] = 1'b1;
      exp_nv = ((hist_m[exp_g] << 1) | int'(ch_bit[exp_g])) & PMASK;
      if ((nbits_m[exp_g] + 1 >= PAT_LEN) && (exp_nv == pat_m)) begin
        exp_mv  = 1'b1;
        exp_mch = CH_W'(exp_g);
      end
    end
    exp_cnt = CNT_EN ? CNT_W'(cnt_m[cnt_sel]) : '0;
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      clear_model();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_clr && int'(cnt_sel) == c) cnt_m[c] = 0;
      else if (exp_mv && int'(exp_mch) == c && cnt_m[c] < CNT_MAX) cnt_m[c]++;
    end
    if (cfg_we) begin
      pat_m = int'(cfg_pattern);
      ptr_m = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        hist_m[c] = 0; nbits_m[c] = 0; cnt_m[c] = 0;
      end
    end else if (exp_g >= 0) begin
      hist_m[exp_g] = exp_nv;
      nbits_m[exp_g]++;
      ptr_m = (exp_g + 1) % NUM_CH;
    end
  endtask

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b);
    @(negedge clk);
    ch_valid = v;
    ch_bit   = b;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [PAT_LEN-1:0] p);
    cfg_we = 1'b1;
    cfg_pattern = p;
    drive(ch_valid, ch_bit);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    drive(4'hF, 4'hA);
    vectors++;
    if (ch_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0000", ch_ready);
    end
    vectors++;
    if (match_valid !== 1'b0 || match_ch !== 2'd0) begin
      miscompares++; $display("FAIL reset_match: got mv=%b ch=%0d want 0/0", match_valid, match_ch);
    end
    vectors++;
    if (cnt_out !== '0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d want 0", cnt_out);
    end
    tick();
    rst_n = 1'b1;
    drive(4'h0, 4'h0);
    vectors++;
    if (ch_ready !== 4'b0000) begin
      miscompares++; $display("FAIL idle_ready: got %b want 0000", ch_ready);
    end
    tick();
  endtask

  task automatic test_single_overlap();
    logic want;
    do_cfg(4'b1010);
    for (int i = 0; i < 6; i++) begin
      want = (i == 3) || (i == 5);
      drive(4'b0001, {3'b000, (i % 2 == 0)});
      vectors++;
      if (ch_ready !== 4'b0001 || ch_ready !== exp_ready) begin
        miscompares++; $display("FAIL single_ready[%0d]: got %b want 0001", i, ch_ready);
      end
      vectors++;
      if (match_valid !== want || match_valid !== exp_mv) begin
        miscompares++; $display("FAIL single_match[%0d]: got %b want %b", i, match_valid, want);
      end
      vectors++;
      if (match_ch !== 2'd0) begin
        miscompares++; $display("FAIL single_ch[%0d]: got %0d want 0", i, match_ch);
      end
      tick();
    end
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_round_robin();
    int grants [NUM_CH];
    logic [NUM_CH-1:0] onehot;
    for (int c = 0; c < NUM_CH; c++) grants[c] = 0;
    do_cfg(4'b1010);
    for (int i = 0; i < 2 * NUM_CH + 1; i++) begin
      onehot = '0;
      onehot[i % NUM_CH] = 1'b1;
      drive(4'hF, NUM_CH'($urandom));
      vectors++;
      if (ch_ready !== onehot || ch_ready !== exp_ready) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ch_ready, onehot);
      end
      vectors++;
      if (match_valid !== exp_mv || match_ch !== exp_mch) begin
        miscompares++; $display("FAIL rr_match[%0d]: got %b/%0d want %b/%0d", i, match_valid, match_ch, exp_mv, exp_mch);
      end
      for (int c = 0; c < NUM_CH; c++) if (ch_ready[c] && i < 2 * NUM_CH) grants[c]++;
      tick();
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vectors++;
      if (grants[c] !== 2) begin
        miscompares++; $display("FAIL rr_fair[%0d]: got %0d grants want 2", c, grants[c]);
      end
    end
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_interleave();
    int idx1, idx2, m1, m2, cyc;
    logic [NUM_CH-1:0] v, b;
    idx1 = 0; idx2 = 0; m1 = 0; m2 = 0; cyc = 0;
    do_cfg(4'b1010);
    while ((idx1 < 4 || idx2 < 4) && cyc < 16) begin
      v = {1'b0, idx2 < 4, idx1 < 4, 1'b0};
      b = {1'b0, idx2 % 2 == 0, idx1 % 2 == 0, 1'b0};
      drive(v, b);
      vectors++;
      if (ch_ready !== exp_ready || match_valid !== exp_mv || match_ch !== exp_mch) begin
        miscompares++; $display("FAIL ilv[%0d]: got rdy=%b mv=%b ch=%0d want rdy=%b mv=%b ch=%0d", cyc, ch_ready, match_valid, match_ch, exp_ready, exp_mv, exp_mch);
      end
      if (match_valid && match_ch == 2'd1) begin
        m1++;
        vectors++;
        if (idx1 !== 3) begin
          miscompares++; $display("FAIL ilv_ch1_pos: got bit %0d want 3", idx1);
        end
      end
      if (match_valid && match_ch == 2'd2) begin
        m2++;
        vectors++;
        if (idx2 !== 3) begin
          miscompares++; $display("FAIL ilv_ch2_pos: got bit %0d want 3", idx2);
        end
      end
      if (exp_g == 1) idx1++;
      if (exp_g == 2) idx2++;
      tick();
      cyc++;
    end
    vectors++;
    if (m1 !== 1 || m2 !== 1 || cyc > 8) begin
      miscompares++; $display("FAIL ilv_count: got m1=%0d m2=%0d cycles=%0d want 1 1 <=8", m1, m2, cyc);
    end
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_cfg_clear();
    logic [6:0] seq;
    logic [6:0] want;
    seq  = 7'b0101010;  // sent LSB first: 0,1,0,1,0,1,0
    want = 7'b1010000;  // overlapping 1010 completes on bits 4 and 6 only
    do_cfg(4'b1010);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, {3'b000, (i % 2 == 0)});
      tick();
    end
    cfg_we = 1'b1;
    cfg_pattern = 4'b1010;
    drive(4'b0001, 4'b0000);
    vectors++;
    if (ch_ready !== 4'b0000 || match_valid !== 1'b0) begin
      miscompares++; $display("FAIL cfg_block: got rdy=%b mv=%b want 0000/0", ch_ready, match_valid);
    end
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(4'b0001, {3'b000, seq[i]});
      vectors++;
      if (match_valid !== want[i] || match_valid !== exp_mv || ch_ready !== 4'b0001) begin
        miscompares++; $display("FAIL cfg_seq[%0d]: got mv=%b rdy=%b want mv=%b rdy=0001", i, match_valid, ch_ready, want[i]);
      end
      tick();
    end
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_reset_midstream();
    do_cfg(4'b1010);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, {3'b000, (i % 2 == 0)});
      tick();
    end
    @(negedge clk);
    ch_valid = 4'b0001;
    ch_bit   = 4'b0000;
    rst_n    = 1'b0;
    clear_model();
    #1;
    model_eval();
    vectors++;
    if (ch_ready !== 4'b0000 || match_valid !== 1'b0 || match_ch !== 2'd0) begin
      miscompares++; $display("FAIL rst_mid: got rdy=%b mv=%b ch=%0d want 0000/0/0", ch_ready, match_valid, match_ch);
    end
    tick();
    rst_n = 1'b1;
    drive(4'b0001, 4'b0000);
    vectors++;
    if (ch_ready !== 4'b0001 || match_valid !== 1'b0 || match_valid !== exp_mv) begin
      miscompares++; $display("FAIL rst_after: got rdy=%b mv=%b want 0001/0", ch_ready, match_valid);
    end
    tick();
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] v, b;
    v = '0; b = '0;
    do_cfg(PAT_LEN'($urandom));
    for (int i = 0; i < 400; i++) begin
      cfg_we      = ($urandom_range(0, 31) == 0);
      cfg_pattern = PAT_LEN'($urandom);
      cnt_sel     = CH_W'($urandom);
      cnt_clr     = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (!v[c]) begin
          v[c] = ($urandom_range(0, 2) != 0);
          b[c] = 1'($urandom);
        end
      end
      drive(v, b);
      vectors++;
      if (ch_ready !== exp_ready) begin
        miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ch_ready, exp_ready);
      end
      vectors++;
      if (match_valid !== exp_mv || match_ch !== exp_mch) begin
        miscompares++; $display("FAIL rnd_match[%0d]: got %b/%0d want %b/%0d", i, match_valid, match_ch, exp_mv, exp_mch);
      end
      vectors++;
      if (cnt_out !== exp_cnt) begin
        miscompares++; $display("FAIL rnd_cnt[%0d]: sel=%0d got %0d want %0d", i, cnt_sel, cnt_out, exp_cnt);
      end
      v = v & ~exp_ready;
      tick();
    end
    cfg_we = 1'b0;
    cnt_clr = 1'b0;
    drive(4'h0, 4'h0);
    tick();
  endtask

  task automatic test_counter();
    cnt_clr = 1'b0;
    cnt_sel = 2'd3;
    do_cfg(4'b1010);
`ifdef SEQ_CNT_EN
    for (int p = 0; p < 301; p++) begin
      for (int j = 0; j < 2; j++) begin
        drive(4'b1000, {(j == 0), 3'b000});
        vectors++;
        if (cnt_out !== exp_cnt || match_valid !== exp_mv) begin
          miscompares++; $display("FAIL cnt_run[%0d]: got cnt=%0d mv=%b want cnt=%0d mv=%b", 2 * p + j, cnt_out, match_valid, exp_cnt, exp_mv);
        end
        tick();
      end
    end
    drive(4'h0, 4'h0);
    vectors++;
    if (cnt_out !== 8'd255) begin
      miscompares++; $display("FAIL cnt_sat: got %0d want 255", cnt_out);
    end
    tick();
    drive(4'b1000, 4'b1000);
    tick();
    cnt_clr = 1'b1;
    drive(4'b1000, 4'b0000);
    vectors++;
    if (match_valid !== 1'b1 || match_ch !== 2'd3) begin
      miscompares++; $display("FAIL cnt_clr_match: got %b/%0d want 1/3", match_valid, match_ch);
    end
    tick();
    cnt_clr = 1'b0;
    drive(4'h0, 4'h0);
    vectors++;
    if (cnt_out !== 8'd0 || cnt_out !== exp_cnt) begin
      miscompares++; $display("FAIL cnt_clr_wins: got %0d want 0", cnt_out);
    end
    tick();
`else
    for (int i = 0; i < 8; i++) begin
      cnt_clr = 1'(i % 3 == 0);
      drive(4'b1000, {(i % 2 == 0), 3'b000});
      vectors++;
      if (cnt_out !== 8'd0 || match_valid !== exp_mv) begin
        miscompares++; $display("FAIL cnt_absent[%0d]: got cnt=%0d mv=%b want 0/%b", i, cnt_out, match_valid, exp_mv);
      end
      tick();
    end
    cnt_clr = 1'b0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_overlap();
    test_round_robin();
    test_interleave();
    test_cfg_clear();
    test_reset_midstream();
    test_random();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
